key_enumerator: RTL



---
 rtl/key_enumerator.sv | 108 ++++++++++
 1 files changed

// File: rtl/key_enumerator.sv
// Captures a pressed-key vector and streams out the index of each pressed key,
// lowest first, over a valid/ready handshake while counting the keys emitted.
module key_enumerator #(
    parameter int WIDTH = 12,
    parameter int IDX_W = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] keys,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] next_mask;

    function automatic logic [IDX_W-1:0] lowest_index(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // Clearing the lowest set bit gives the mask that remains after a handshake.
    assign next_mask = mask & (mask - WIDTH'(1));

    // Outputs are registered and precomputed from the mask that will be held next,
    // so nothing downstream sees a combinational path from out_ready or keys.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mask      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask  <= keys;
                        count <= '0;
                        busy  <= 1'b1;
                        if (keys != '0) begin
                            state     <= SEND;
                            out_valid <= 1'b1;
                            out_index <= lowest_index(keys);
                            out_last  <= single_bit(keys);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        mask  <= next_mask;
                        count <= count + CNT_W'(1);
                        if (out_last) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_index <= lowest_index(next_mask);
                            out_last  <= single_bit(next_mask);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
